// File: rtl/mdu_pkg.sv
// Shared opcode, state and latency definitions for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Default busy latencies, also used by the hazard unit for stall sizing.
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide datapath. res = {hi, lo}; valid drops on divide by zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        valid
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] bu_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign b_zero = (b == '0);

  // Signed divide via magnitudes: avoids the INT_MIN / -1 corner, which wraps back to 0x80000000.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b_zero ? 32'd1 : (b[31] ? (~b + 32'd1) : b);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign bu_safe = b_zero ? 32'd1 : b;
  assign q_u     = a / bu_safe;
  assign r_u     = a % bu_safe;

  // Select the result for the requested operation.
  always_comb begin
    res   = '0;
    valid = 1'b0;
    case (op)
      MD_MULT:  begin res = prod_s;      valid = 1'b1;    end
      MD_MULTU: begin res = prod_u;      valid = 1'b1;    end
      MD_DIV:   begin res = {r_s, q_s};  valid = !b_zero; end
      MD_DIVU:  begin res = {r_u, q_u};  valid = !b_zero; end
      default:  begin res = '0;          valid = 1'b0;    end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO pair.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        cancel,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_vld_q, res_vld_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_res;
  logic             arith_vld;

  mdu_arith u_arith (
    .op    (mdop),
    .a     (srcA),
    .b     (srcB),
    .res   (arith_res),
    .valid (arith_vld)
  );

  // Next-state, counter, result capture and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_vld_d = res_vld_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (mdop)
            MD_MULT, MD_MULTU: begin
              res_hi_d  = arith_res[63:32];
              res_lo_d  = arith_res[31:0];
              res_vld_d = arith_vld;
              cnt_d     = CNT_W'(MULT_LAT);
              state_d   = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              res_hi_d  = arith_res[63:32];
              res_lo_d  = arith_res[31:0];
              res_vld_d = arith_vld;
              cnt_d     = CNT_W'(DIV_LAT);
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = srcA;
            MD_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Cancel takes priority over the commit on the final busy cycle.
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (res_vld_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_vld_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_vld_q <= res_vld_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo against a plain-arithmetic HI/LO model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int unsigned T_MULT_LAT = 5;
  localparam int unsigned T_DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        rd_hi;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mdu_hilo #(
    .MULT_LAT (T_MULT_LAT),
    .DIV_LAT  (T_DIV_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mdop    (mdop),
    .srcA    (srcA),
    .srcB    (srcB),
    .cancel  (cancel),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one operation, computed with 64-bit integer arithmetic.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ch, input logic [31:0] cl,
                                   output logic [31:0] nh, output logic [31:0] nl,
                                   output int unsigned lat);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = ch;
    nl = cl;
    lat = 0;
    case (op)
      MD_MULT:  begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; lat = T_MULT_LAT; end
      MD_MULTU: begin pu = ua * ub; nh = pu[63:32]; nl = pu[31:0]; lat = T_MULT_LAT; end
      MD_DIV: begin
        lat = T_DIV_LAT;
        if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      MD_DIVU: begin
        lat = T_DIV_LAT;
        if (b != 0) begin qu = ua / ub; ru = ua % ub; nl = qu[31:0]; nh = ru[31:0]; end
      end
      MD_MTHI: nh = a;
      MD_MTLO: nl = a;
      default: ;
    endcase
  endfunction

  // Issue one operation at a negedge, follow it to completion and compare against the model.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int unsigned lat, n;
    ref_calc(op, a, b, exp_hi, exp_lo, nh, nl, lat);
    start = 1'b1; mdop = op; srcA = a; srcB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      check_eq("hold_hi", hi, exp_hi);
      check_eq("hold_lo", lo, exp_lo);
      check_eq("hold_rd", rd_data, rd_hi ? exp_hi : exp_lo);
      @(negedge clk);
    end
    check_eq("busy_len", 64'(n), 64'(lat));
    exp_hi = nh;
    exp_lo = nl;
    check_eq("res_hi", hi, exp_hi);
    check_eq("res_lo", lo, exp_lo);
    check_eq("res_rd", rd_data, rd_hi ? exp_hi : exp_lo);
  endtask

  // DIV aborted by cancel on busy cycle k.
  task automatic cancel_div(input int unsigned k);
    start = 1'b1; mdop = MD_DIV; srcA = 32'd1000; srcB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 1; i < k; i++) begin
      check_eq("cxl_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check_eq("cxl_busy_last", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cxl_idle", 64'(busy), 64'd0);
    check_eq("cxl_hi", hi, exp_hi);
    check_eq("cxl_lo", lo, exp_lo);
    repeat (T_DIV_LAT + 2) @(negedge clk);
    check_eq("cxl_idle_late", 64'(busy), 64'd0);
    check_eq("cxl_hi_late", hi, exp_hi);
    check_eq("cxl_lo_late", lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  ops [6];
    logic [31:0] ra, rb;
    int unsigned n;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

    rst_n = 1'b0; start = 1'b0; mdop = '0; srcA = '0; srcB = '0; cancel = 1'b0; rd_hi = 1'b0;
    exp_hi = '0; exp_lo = '0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with independently known results.
    do_op(MD_MTHI, 32'hAAAA_5555, 32'd0);
    do_op(MD_MTLO, 32'h0F0F_F0F0, 32'd0);
    rd_hi = 1'b1;
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check_eq("mult_hi_k", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo_k", lo, 32'hFFFF_FFFA);
    rd_hi = 1'b0;
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("multu_hi_k", hi, 32'hFFFF_FFFE);
    check_eq("multu_lo_k", lo, 32'h0000_0001);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_lo_k", lo, 32'hFFFF_FFFD);
    check_eq("div_hi_k", hi, 32'hFFFF_FFFF);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divovf_lo_k", lo, 32'h8000_0000);
    check_eq("divovf_hi_k", hi, 32'h0000_0000);
    do_op(MD_MTHI, 32'h1357_9BDF, 32'd0);
    do_op(MD_DIVU, 32'd7, 32'd0);
    check_eq("div0_hi_k", hi, 32'h1357_9BDF);
    check_eq("div0_lo_k", lo, 32'h8000_0000);

    // Back-to-back MTHI/MTLO.
    start = 1'b1; mdop = MD_MTHI; srcA = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    mdop = MD_MTLO; srcA = 32'h9ABC_DEF0;
    check_eq("mt_busy0", 64'(busy), 64'd0);
    check_eq("mthi_val", hi, 32'h1234_5678);
    rd_hi = 1'b1; #1;
    check_eq("mthi_rd", rd_data, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("mt_busy1", 64'(busy), 64'd0);
    check_eq("mtlo_val", lo, 32'h9ABC_DEF0);
    rd_hi = 1'b0; #1;
    check_eq("mtlo_rd", rd_data, 32'h9ABC_DEF0);
    rd_hi = 1'b1; #1;
    check_eq("mthi_rd2", rd_data, 32'h1234_5678);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h9ABC_DEF0;
    @(negedge clk);

    // Cancel mid-operation and on the would-be commit edge.
    cancel_div(4);
    cancel_div(T_DIV_LAT);

    // Cancel in IDLE drops any start, including moves.
    start = 1'b1; cancel = 1'b1; mdop = MD_MTHI; srcA = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mdop = MD_MULT; srcA = 32'd3; srcB = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check_eq("idlecxl_busy", 64'(busy), 64'd0);
    check_eq("idlecxl_hi", hi, exp_hi);
    check_eq("idlecxl_lo", lo, exp_lo);

    // A start during RUN is ignored.
    start = 1'b1; mdop = MD_MULT; srcA = 32'd6; srcB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 2) begin
        start = 1'b1; mdop = MD_DIVU; srcA = 32'd100; srcB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("ign_len", 64'(n), 64'(T_MULT_LAT));
    check_eq("ign_hi", hi, 32'd0);
    check_eq("ign_lo", lo, 32'd42);
    @(negedge clk);
    check_eq("ign_idle", 64'(busy), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd42;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rd_hi = 1'($urandom_range(0, 1));
      do_op(ops[$urandom_range(0, 5)], ra, rb);
    end

    // Asynchronous reset in the middle of a MULT.
    do_op(MD_MTHI, 32'hCAFE_F00D, 32'd0);
    start = 1'b1; mdop = MD_MULT; srcA = 32'd9; srcB = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_hi", hi, 32'd0);
    check_eq("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (T_MULT_LAT + 1) @(negedge clk);
    check_eq("arst_nocommit_hi", hi, 32'd0);
    check_eq("arst_nocommit_lo", lo, 32'd0);
    do_op(MD_MULTU, 32'd100000, 32'd300000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
